// File: rtl/whirlpool_pkg.sv
// Shared constants and types for the Whirlpool datapath.
// Bit 0 of every block/word vector is the most significant, first-transmitted bit.
package whirlpool_pkg;

    localparam int WP_BLOCK_BITS     = 512;
    localparam int WP_WORD_BITS      = 64;
    localparam int WP_LEN_FIELD_BITS = 256;
    localparam int WP_LEN_OFFSET     = WP_BLOCK_BITS - WP_LEN_FIELD_BITS;

    localparam logic [7:0] WP_PAD_BYTE = 8'h80;

    // Highest end offset whose 0x80 byte still leaves room for the length field.
    localparam logic [6:0] WP_LEN_LAST_OFF = 7'd31;

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        EMIT_EXTRA
    } wp_pad_state_t;

    // Byte position inside the block just past the last message byte (0..64).
    function automatic logic [6:0] wp_end_offset(input logic [2:0] wptr,
                                                 input logic [3:0] nbytes);
        return {1'b0, wptr, 3'b000} + {3'b000, nbytes};
    endfunction

endpackage

// File: rtl/whirlpool_pad_word_mask.sv
// Keeps the first nbytes bytes of a word, writes the 0x80 pad marker at byte
// nbytes (when it falls inside the word) and zeroes everything after it.
module whirlpool_pad_word_mask
    import whirlpool_pkg::*;
(
    input  logic [0:WP_WORD_BITS-1] data,
    input  logic [3:0]              nbytes,
    output logic [0:WP_WORD_BITS-1] word
);

    always_comb begin
        // NOTE: default first so every path assigns word and no latch is inferred.
        word = '0;
        for (int k = 0; k < WP_WORD_BITS / 8; k++) begin
            if (4'(k) < nbytes) begin
                word[8*k +: 8] = data[8*k +: 8];
            end else if (4'(k) == nbytes) begin
                word[8*k +: 8] = WP_PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/whirlpool_msg_pad_packer.sv
// Packs 64-bit message words into 512-bit Whirlpool blocks and applies the
// MD-strengthening padding (0x80, zero fill, 256-bit big-endian bit length).
module whirlpool_msg_pad_packer
    import whirlpool_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [0:WP_WORD_BITS-1]  in_data,
    input  logic                     in_last,
    input  logic [3:0]               in_nbytes,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic [0:WP_BLOCK_BITS-1] blk_data,
    output logic                     blk_last
);

    wp_pad_state_t      state;
    logic [2:0]         wptr;
    logic [LEN_W-1:0]   bit_cnt;
    logic               extra_pending;
    logic               mark_pending;

    logic               xfer;
    logic [3:0]         nbytes_eff;
    logic [0:WP_WORD_BITS-1]  word;
    logic [6:0]         end_off;
    logic [LEN_W-1:0]   next_bits;
    logic [8:0]         slot_base;
    logic [8:0]         next_base;
    logic [0:WP_BLOCK_BITS-1] fill_blk;
    logic [0:WP_BLOCK_BITS-1] extra_blk;

    // in_ready is only ever high in FILL, so it alone qualifies a transfer.
    assign xfer       = in_valid && in_ready;
    assign nbytes_eff = in_last ? in_nbytes : 4'd8;
    assign end_off    = wp_end_offset(wptr, nbytes_eff);
    assign next_bits  = bit_cnt + LEN_W'({nbytes_eff, 3'b000});
    assign slot_base  = {wptr, 6'b000000};
    assign next_base  = {wptr + 3'd1, 6'b000000};

    whirlpool_pad_word_mask u_mask (
        .data   (in_data),
        .nbytes (nbytes_eff),
        .word   (word)
    );

    // Block as it looks after the current word is written into slot wptr.
    always_comb begin
        fill_blk = blk_data;
        fill_blk[slot_base +: WP_WORD_BITS] = word;
        if (in_last) begin
            for (int j = 0; j < WP_BLOCK_BITS / WP_WORD_BITS; j++) begin
                if (3'(j) > wptr) begin
                    fill_blk[WP_WORD_BITS*j +: WP_WORD_BITS] = '0;
                end
            end
            // A full final word pushes the pad marker into the next slot.
            if (nbytes_eff == 4'd8 && wptr != 3'd7) begin
                fill_blk[next_base +: 8] = WP_PAD_BYTE;
            end
            if (end_off <= WP_LEN_LAST_OFF) begin
                fill_blk[WP_LEN_OFFSET +: WP_LEN_FIELD_BITS] = WP_LEN_FIELD_BITS'(next_bits);
            end
        end
    end

    always_comb begin
        extra_blk = '0;
        extra_blk[0 +: 8] = mark_pending ? WP_PAD_BYTE : 8'h00;
        extra_blk[WP_LEN_OFFSET +: WP_LEN_FIELD_BITS] = WP_LEN_FIELD_BITS'(bit_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the 512-bit block register doubles as the assembly buffer, so it
            // is reset to guarantee no stale bytes survive into the next message.
            state         <= FILL;
            wptr          <= '0;
            bit_cnt       <= '0;
            extra_pending <= 1'b0;
            mark_pending  <= 1'b0;
            in_ready      <= 1'b0;
            blk_valid     <= 1'b0;
            blk_last      <= 1'b0;
            blk_data      <= '0;
        end else begin
            // NOTE: non-blocking everywhere here; every branch reads pre-edge values.
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        bit_cnt  <= next_bits;
                        blk_data <= fill_blk;
                        if (in_last || wptr == 3'd7) begin
                            state         <= EMIT;
                            in_ready      <= 1'b0;
                            blk_valid     <= 1'b1;
                            blk_last      <= in_last && (end_off <= WP_LEN_LAST_OFF);
                            extra_pending <= in_last && (end_off > WP_LEN_LAST_OFF);
                            mark_pending  <= in_last && (end_off == 7'd64);
                        end else begin
                            wptr <= wptr + 3'd1;
                        end
                    end
                end

                EMIT, EMIT_EXTRA: begin
                    if (blk_ready) begin
                        if (blk_last) begin
                            state         <= FILL;
                            wptr          <= '0;
                            bit_cnt       <= '0;
                            extra_pending <= 1'b0;
                            mark_pending  <= 1'b0;
                            in_ready      <= 1'b1;
                            blk_valid     <= 1'b0;
                            blk_last      <= 1'b0;
                            blk_data      <= '0;
                        end else if (extra_pending) begin
                            state         <= EMIT_EXTRA;
                            blk_data      <= extra_blk;
                            blk_last      <= 1'b1;
                            extra_pending <= 1'b0;
                            mark_pending  <= 1'b0;
                        end else begin
                            // Mid-message block: keep the running length.
                            state     <= FILL;
                            wptr      <= '0;
                            in_ready  <= 1'b1;
                            blk_valid <= 1'b0;
                            blk_data  <= '0;
                        end
                    end
                end

                default: state <= FILL;
            endcase
        end
    end

    a_nbytes_legal: assert property (@(posedge clk) disable iff (rst)
        (in_valid && in_ready && in_last) |-> (in_nbytes <= 4'd8));

endmodule

// File: tb/tb_whirlpool_msg_pad_packer.sv
// Randomized bench for whirlpool_msg_pad_packer against a byte-level model of
// Whirlpool padding (append 0x80, zero fill, 256-bit big-endian bit length).
module tb_whirlpool_msg_pad_packer;
    import whirlpool_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:63]  in_data = '0;
    logic         in_last = 1'b0;
    logic [3:0]   in_nbytes = '0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [0:511] blk_data;
    logic         blk_last;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { logic [0:63] data; logic last; logic [3:0] nb; } word_t;
    typedef struct { logic [0:511] data; logic last; } blk_t;

    word_t        wq[$];
    blk_t         eq[$];
    logic [7:0]   cur_msg[$];
    logic [0:511] last_blk = '0;
    int           hs_cycles[$];

    always #5 clk = ~clk;

    whirlpool_msg_pad_packer #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    task automatic rand_msg(input int len);
        cur_msg.delete();
        repeat (len) cur_msg.push_back(8'($urandom));
    endtask

    // Splits cur_msg into input words and queues the expected padded blocks.
    task automatic add_message(input bit trailing_empty);
        int len = cur_msg.size();
        int nfull = len / 8;
        int rem = len % 8;
        logic [7:0] pad[$];
        logic [63:0] bitlen;
        word_t w;
        blk_t b;
        if (rem == 0 && len > 0 && !trailing_empty) begin
            nfull = nfull - 1;
            rem = 8;
        end
        for (int i = 0; i < nfull; i++) begin
            for (int k = 0; k < 8; k++) w.data[8*k +: 8] = cur_msg[8*i+k];
            w.last = 1'b0;
            w.nb = 4'd8;
            wq.push_back(w);
        end
        for (int k = 0; k < 8; k++) w.data[8*k +: 8] = (k < rem) ? cur_msg[8*nfull+k] : 8'($urandom);
        w.last = 1'b1;
        w.nb = 4'(rem);
        wq.push_back(w);
        pad = cur_msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 32) pad.push_back(8'h00);
        repeat (24) pad.push_back(8'h00);
        bitlen = 64'(len) * 64'd8;
        for (int k = 7; k >= 0; k--) pad.push_back(bitlen[8*k +: 8]);
        for (int bi = 0; bi < pad.size() / 64; bi++) begin
            for (int k = 0; k < 64; k++) b.data[8*k +: 8] = pad[64*bi+k];
            b.last = (bi == pad.size() / 64 - 1);
            eq.push_back(b);
        end
    endtask

    // Streams the word queue in and checks every block handshake against the model.
    task automatic run_stream(input int ready_pct, input int valid_pct);
        int cyc = 0;
        bit holding = 1'b0;
        logic [0:511] held = '0;
        hs_cycles.delete();
        while ((wq.size() > 0 || eq.size() > 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            vectors++;
            if (blk_valid && in_ready) begin
                miscompares++;
                $display("FAIL excl: in_ready=%b with blk_valid=1, required in_ready=0", in_ready);
            end
            if (holding && blk_valid) begin
                vectors++;
                if (blk_data !== held) begin
                    miscompares++;
                    $display("FAIL hold: blk_data=%h changed, required %h", blk_data, held);
                end
            end
            blk_ready = ($urandom_range(99) < ready_pct);
            holding = blk_valid && !blk_ready;
            held = blk_data;
            if (blk_valid && blk_ready) begin
                vectors++;
                if (eq.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_block: got %h, required no block", blk_data);
                end else begin
                    if (blk_data !== eq[0].data || blk_last !== eq[0].last) begin
                        miscompares++;
                        $display("FAIL block: got last=%b %h, required last=%b %h",
                                 blk_last, blk_data, eq[0].last, eq[0].data);
                    end
                    void'(eq.pop_front());
                end
                last_blk = blk_data;
                hs_cycles.push_back(cyc);
            end
            if (wq.size() > 0 && $urandom_range(99) < valid_pct) begin
                in_valid = 1'b1;
                in_data = wq[0].data;
                in_last = wq[0].last;
                in_nbytes = wq[0].nb;
                if (in_ready) void'(wq.pop_front());
            end else begin
                in_valid = 1'b0;
                in_data = {$urandom, $urandom};
                in_last = 1'($urandom);
                in_nbytes = 4'($urandom_range(8));
            end
        end
        if (wq.size() > 0 || eq.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: %0d words and %0d blocks outstanding, required 0", wq.size(), eq.size());
            wq.delete();
            eq.delete();
        end
        @(negedge clk);
        in_valid = 1'b0;
        blk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_last !== 1'b0 || blk_data !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: in_ready=%b blk_valid=%b blk_last=%b data=%h, required all 0",
                     in_ready, blk_valid, blk_last, blk_data);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b blk_valid=%b, required 1/0", in_ready, blk_valid);
        end
    endtask

    task automatic test_empty();
        logic [0:511] exp = '0;
        exp[0:7] = 8'h80;
        cur_msg.delete();
        add_message(1'b0);
        run_stream(100, 100);
        vectors++;
        if (last_blk !== exp) begin
            miscompares++;
            $display("FAIL empty: got %h, required %h", last_blk, exp);
        end
    endtask

    task automatic test_abc();
        logic [0:511] exp = '0;
        exp[0:31] = 32'h61626380;
        exp[504:511] = 8'h18;
        cur_msg.delete();
        cur_msg.push_back(8'h61);
        cur_msg.push_back(8'h62);
        cur_msg.push_back(8'h63);
        add_message(1'b0);
        run_stream(100, 100);
        vectors++;
        if (last_blk !== exp) begin
            miscompares++;
            $display("FAIL abc: got %h, required %h", last_blk, exp);
        end
    endtask

    task automatic test_32_bytes();
        logic [0:511] exp = '0;
        exp[496:503] = 8'h01;
        rand_msg(32);
        add_message(1'b0);
        run_stream(100, 100);
        vectors++;
        if (hs_cycles.size() !== 2 || last_blk !== exp) begin
            miscompares++;
            $display("FAIL len32: %0d blocks, last %h, required 2 blocks, last %h",
                     hs_cycles.size(), last_blk, exp);
        end
    endtask

    task automatic test_trailing_empty();
        int lens[7] = '{8, 24, 32, 56, 64, 120, 128};
        foreach (lens[i]) begin
            rand_msg(lens[i]);
            add_message(1'b1);
        end
        run_stream(70, 70);
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        logic [0:511] held;
        logic [0:511] exp = '0;
        exp[0:7] = 8'h80;
        exp[496:503] = 8'h02;
        rand_msg(64);
        add_message(1'b0);
        blk_ready = 1'b0;
        while (cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (blk_valid) break;
            if (wq.size() > 0) begin
                in_valid = 1'b1;
                in_data = wq[0].data;
                in_last = wq[0].last;
                in_nbytes = wq[0].nb;
                if (in_ready) void'(wq.pop_front());
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (blk_valid !== 1'b1 || wq.size() != 0) begin
            miscompares++;
            $display("FAIL bp_wait: blk_valid=%b words left=%0d, required 1/0", blk_valid, wq.size());
        end
        held = blk_data;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (blk_valid !== 1'b1 || in_ready !== 1'b0 || blk_last !== 1'b0 || blk_data !== held) begin
                miscompares++;
                $display("FAIL bp_hold: valid=%b in_ready=%b last=%b data=%h, required 1/0/0 %h",
                         blk_valid, in_ready, blk_last, blk_data, held);
            end
        end
        vectors++;
        if (held !== eq[0].data) begin
            miscompares++;
            $display("FAIL bp_block1: got %h, required %h", held, eq[0].data);
        end
        void'(eq.pop_front());
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (blk_valid !== 1'b1 || blk_last !== 1'b1 || blk_data !== eq[0].data) begin
            miscompares++;
            $display("FAIL bp_single: valid=%b last=%b data=%h, required 1/1 %h",
                     blk_valid, blk_last, blk_data, eq[0].data);
        end
        run_stream(100, 100);
        vectors++;
        if (last_blk !== exp) begin
            miscompares++;
            $display("FAIL len64_extra: got %h, required %h", last_blk, exp);
        end
    endtask

    task automatic test_back_to_back();
        rand_msg(512);
        add_message(1'b0);
        run_stream(100, 100);
        vectors++;
        if (hs_cycles.size() !== 9) begin
            miscompares++;
            $display("FAIL b2b_count: %0d blocks, required 9", hs_cycles.size());
        end else begin
            vectors++;
            if (hs_cycles[7] - hs_cycles[0] !== 63 || hs_cycles[8] - hs_cycles[7] !== 1) begin
                miscompares++;
                $display("FAIL b2b_rate: span %0d gap %0d, required 63 and 1",
                         hs_cycles[7] - hs_cycles[0], hs_cycles[8] - hs_cycles[7]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        int accepted = 0;
        logic [0:511] exp = '0;
        exp[0:31] = 32'h61626380;
        exp[504:511] = 8'h18;
        while (accepted < 3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b1;
            in_data = {$urandom, $urandom};
            in_last = 1'b0;
            in_nbytes = 4'd8;
            if (in_ready) accepted++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b0 || blk_data !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: blk_valid=%b in_ready=%b data=%h, required 0/0/0",
                     blk_valid, in_ready, blk_data);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_release: in_ready=%b, required 1", in_ready);
        end
        cur_msg.delete();
        cur_msg.push_back(8'h61);
        cur_msg.push_back(8'h62);
        cur_msg.push_back(8'h63);
        add_message(1'b0);
        run_stream(100, 100);
        vectors++;
        if (last_blk !== exp) begin
            miscompares++;
            $display("FAIL abc_after_reset: got %h, required %h", last_blk, exp);
        end
    endtask

    task automatic test_random();
        repeat (30) begin
            rand_msg($urandom_range(0, 200));
            add_message(1'($urandom));
        end
        run_stream(60, 75);
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_32_bytes();
        test_trailing_empty();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/whirlpool_msg_pad_packer.md
# whirlpool_msg_pad_packer

Upstream stage of the Whirlpool compression datapath. It accepts the message as a stream of 64-bit words and applies Whirlpool MD-strengthening padding: a single `1` bit, zero fill, then a 256-bit big-endian bit-length field. It emits complete 512-bit blocks in left-to-right bit order, ready for the vector-to-matrix unpack stage. Blocks are held under a valid/ready handshake until consumed.

## Interface
- `LEN_W`, default 64: width of the internal message bit-length counter. It is right-aligned in the 256-bit length field, and the upper bits are zero.
- `clk` input 1: clock. One clock domain; all logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: the input word is valid.
- `in_ready` output 1: the block can accept a word this cycle.
- `in_data` input [0:63]: message word. `in_data[0:7]` is the first byte.
- `in_last` input 1: this word is the final word of the message.
- `in_nbytes` input 4: count of valid leading bytes in the last word, 0..8. It is ignored when `in_last`=0; non-last words always carry 8 bytes.
- `blk_valid` output 1: `blk_data` holds a complete block.
- `blk_ready` input 1: the downstream stage consumes the block.
- `blk_data` output [0:511]: padded block. Byte k is `blk_data[8k:8k+7]`; word j is `blk_data[64j:64j+63]`.
- `blk_last` output 1: this block is the final block of the message and carries the length field.

## Operation
- States:
  - FILL: `in_ready`=1; accept words into word slot `wptr` (0..7).
  - EMIT: `blk_valid`=1; hold `blk_data` until the handshake completes.
  - EMIT_EXTRA: identical to EMIT; it presents the extra padding block.
- A word transfers when `in_valid && in_ready`. The byte counter increments by 8, or by `in_nbytes` on the last word. The bit length is `8*bytes`, modulo 2^LEN_W (wraps).
- Non-last word in slot 7: go to EMIT with `blk_last`=0. Afterwards, clear the buffer, set `wptr`=0 and return to FILL. The length counter is kept.
- Last word with message end offset p (byte position in the block, 0..64):
  - Bytes p..63 of the current block are zeroed.
  - If p≤63, byte p = 0x80.
  - If p≤31: write the length into bits 256..511 and go to EMIT with `blk_last`=1.
  - If 32≤p≤63: go to EMIT with `blk_last`=0, and set `extra_pending`.
  - If p=64: go to EMIT with `blk_last`=0, and set `extra_pending` and `mark_pending`.
- EMIT handshake with `extra_pending`: on the next cycle, load the extra block and enter EMIT_EXTRA with `blk_last`=1. The extra block is all zeros, with byte0=0x80 if `mark_pending`, and the length field in bits 256..511.
- Handshake of a `blk_last`=1 block: clear all counters and flags, then return to FILL.
- `in_nbytes`>8 on a last word is illegal and flagged by an assertion. `in_nbytes`=0 on a last word is legal (trailing empty word, or an empty message).
- While in EMIT or EMIT_EXTRA, input is never accepted; `in_valid` is simply not sampled.

## Timing
- Reset values: `in_ready`=0 while `rst` is high; `blk_valid`=0, `blk_last`=0, `blk_data`=0. State=FILL, `wptr`=0, counters=0.
- `in_ready`=1 on the first cycle after `rst` deasserts.
- Reset mid-operation discards the partial block and any pending extra block. Outputs return to reset values on the next edge.
- `blk_valid` rises on the cycle after the completing word transfers (1-cycle latency). All outputs are registered.
- While `blk_valid`=1 and `blk_ready`=0, `blk_data` and `blk_last` are stable.
- After an EMIT handshake, the next cycle is either FILL with `in_ready`=1, or EMIT_EXTRA with `blk_valid`=1.
- Sustained throughput is one block per 9 cycles with `blk_ready` tied high.

## Structure
- Shared package `whirlpool_pkg` holds:
  - `WP_BLOCK_BITS`=512
  - `WP_WORD_BITS`=64
  - `WP_LEN_FIELD_BITS`=256
  - `WP_PAD_BYTE`=8'h80
  - the state enum `wp_pad_state_t` (FILL, EMIT, EMIT_EXTRA)
- One sub-module, `whirlpool_pad_word_mask`: combinational. Given `in_data` and `in_nbytes`, it produces the masked word with 0x80 inserted at byte `in_nbytes` (when `in_nbytes`<8).

## Test plan
- Empty message: one word with `in_last`=1, `in_nbytes`=0 → one block with byte0=0x80, all else 0, length 0, `blk_last`=1.
- "abc": `in_data`=0x616263xx…, `in_nbytes`=3 → bytes0..3 = 61 62 63 80, byte63=0x18, all else 0, `blk_last`=1.
- 32-byte message (4 full words, last `in_nbytes`=8) → two blocks:
  - block 1: byte32=0x80, `blk_last`=0;
  - block 2: all zero except byte62=0x01, byte63=0x00 (length 256), `blk_last`=1.
- 64-byte message → two blocks:
  - block 1: data only, `blk_last`=0;
  - block 2: byte0=0x80, byte62=0x02 (length 512), `blk_last`=1.
- Backpressure: hold `blk_ready`=0 for 5 cycles during EMIT → `blk_data` constant, `in_ready`=0. Releasing `blk_ready` gives exactly one handshake.
- Reset after 3 words are accepted → next cycle `blk_valid`=0. A new "abc" then yields the exact "abc" block, with no stale bytes or length.
